// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle 4-op core with handshaked fetch, internal data memory and single-step
module multicycle_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int MEM_AW = 3,
  localparam int NUM_REGS = 2 ** REG_AW,
  localparam int INSTR_W = 2 + 3 * REG_AW,
  localparam int MEM_DEPTH = 2 ** MEM_AW
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               StepMode,
  input  logic               Step,
  output logic               InstrReq,
  input  logic               InstrValid,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [DATA_W-1:0]  CurrentPC,
  output logic               RegWriteValid,
  output logic [DATA_W-1:0]  RegWriteData,
  output logic               MemWriteValid,
  output logic [DATA_W-1:0]  MemWriteData,
  output logic               Paused
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PAUSE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  state_t state, state_nx;

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  pc;
  logic [DATA_W-1:0]  opa, opb;
  logic [MEM_AW-1:0]  addr;
  logic [DATA_W-1:0]  rwdata, mwdata;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  mem  [MEM_DEPTH];

  logic [1:0]        op;
  logic [REG_AW-1:0] rs, rt, imm, dst;
  logic [DATA_W-1:0] sext_imm, sum, pc_inc, jump_target;
  state_t            retire_state;

  // Instruction field decode and the shared adder used for ADD results and LW/SW addresses
  always_comb begin
    op           = ir[INSTR_W-1 -: 2];
    rs           = ir[3*REG_AW-1 -: REG_AW];
    rt           = ir[2*REG_AW-1 -: REG_AW];
    imm          = ir[REG_AW-1:0];
    dst          = (op == OP_ADD) ? imm : rt;
    sext_imm     = {{(DATA_W-REG_AW){imm[REG_AW-1]}}, imm};
    sum          = opa + ((op == OP_ADD) ? opb : sext_imm);
    pc_inc       = pc + DATA_W'(1);
    jump_target  = pc_inc + sext_imm;
    retire_state = StepMode ? S_PAUSE : S_FETCH;
  end

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Next-state sequencing and per-state strobes
  always_comb begin
    state_nx      = state;
    InstrReq      = 1'b0;
    Paused        = 1'b0;
    RegWriteValid = 1'b0;
    MemWriteValid = 1'b0;
    case (state)
      S_FETCH: begin
        InstrReq = 1'b1;
        if (InstrValid) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ADD:  state_nx = S_WB;
          OP_LW:   state_nx = S_MEM;
          OP_SW:   state_nx = S_MEM;
          default: state_nx = retire_state;
        endcase
      end
      S_MEM: begin
        MemWriteValid = (op == OP_SW);
        state_nx      = (op == OP_LW) ? S_WB : retire_state;
      end
      S_WB: begin
        RegWriteValid = 1'b1;
        state_nx      = retire_state;
      end
      S_PAUSE: begin
        Paused = 1'b1;
        if (Step || !StepMode) state_nx = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // Datapath: operand latches, result/store data, PC, register file and data memory
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ir     <= '0;
      pc     <= '0;
      opa    <= '0;
      opb    <= '0;
      addr   <= '0;
      rwdata <= '0;
      mwdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(i);
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (InstrValid) ir <= Instruction;
        end
        S_DECODE: begin
          opa <= regs[rs];
          opb <= regs[rt];
        end
        S_EXEC: begin
          addr <= sum[MEM_AW-1:0];
          if (op == OP_ADD) rwdata <= sum;
          if (op == OP_SW)  mwdata <= opb;
          if (op == OP_J)   pc     <= jump_target;
        end
        S_MEM: begin
          if (op == OP_SW) begin
            mem[addr] <= opb;
            pc        <= pc_inc;
          end else begin
            rwdata <= mem[addr];
          end
        end
        S_WB: begin
          regs[dst] <= rwdata;
          pc        <= pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign CurrentPC    = pc;
  assign RegWriteData = rwdata;
  assign MemWriteData = mwdata;

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - randomized self-checking bench for multicycle_core against an ISA-level model
module tb_multicycle_core;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       StepMode = 1'b0;
  logic       Step = 1'b0;
  logic       InstrValid = 1'b0;
  logic [7:0] Instruction = 8'h00;
  logic       InstrReq, RegWriteValid, MemWriteValid, Paused;
  logic [7:0] CurrentPC, RegWriteData, MemWriteData;

  multicycle_core #(.DATA_W(8), .REG_AW(2), .MEM_AW(3)) dut (
    .CLK(CLK), .Reset(Reset), .StepMode(StepMode), .Step(Step),
    .InstrReq(InstrReq), .InstrValid(InstrValid), .Instruction(Instruction),
    .CurrentPC(CurrentPC), .RegWriteValid(RegWriteValid), .RegWriteData(RegWriteData),
    .MemWriteValid(MemWriteValid), .MemWriteData(MemWriteData), .Paused(Paused)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_regs [4];
  logic [7:0] m_mem  [8];
  logic [7:0] m_pc, m_last_rw, m_last_mw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] sx(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'(i);
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_pc = 8'h00;
    m_last_rw = 8'h00;
    m_last_mw = 8'h00;
  endtask

  task automatic run_instr(input logic [7:0] ins, input int wait_cycles,
                           input bit step_mode, input bit early_step);
    logic [1:0] op, rs, rt, rd;
    logic [7:0] val, npc, ea;
    int lat;
    bit regw, memw;
    op = ins[7:6]; rs = ins[5:4]; rt = ins[3:2]; rd = ins[1:0];
    ea = m_regs[rs] + sx(rd);
    regw = 0; memw = 0; val = 8'h00;
    npc = m_pc + 8'd1;
    case (op)
      2'b00: begin val = m_regs[rs] + m_regs[rt]; lat = 3; regw = 1; end
      2'b01: begin val = m_mem[ea[2:0]]; lat = 4; regw = 1; end
      2'b10: begin val = m_regs[rt]; lat = 3; memw = 1; end
      default: begin lat = 2; npc = m_pc + 8'd1 + sx(rd); end
    endcase

    StepMode = step_mode;
    check("fetch_req", InstrReq, 1);
    check("fetch_pc", CurrentPC, m_pc);
    for (int w = 0; w < wait_cycles; w++) begin
      InstrValid = 1'b0;
      Instruction = 8'($urandom);
      tick();
      check("wait_req", InstrReq, 1);
      check("wait_pc", CurrentPC, m_pc);
      check("wait_rwv", RegWriteValid, 0);
    end
    Instruction = ins;
    InstrValid = 1'b1;
    tick();
    InstrValid = ($urandom_range(0, 1) == 1);
    Instruction = 8'($urandom);

    for (int k = 1; k <= lat; k++) begin
      Step = (early_step && k == 2);
      check("busy_req", InstrReq, 0);
      check("busy_paused", Paused, 0);
      check("busy_pc", CurrentPC, m_pc);
      check("rwv", RegWriteValid, (regw && k == lat));
      check("mwv", MemWriteValid, (memw && k == 3));
      if (regw && k == lat) check("rwdata", RegWriteData, val);
      if (memw && k == 3)   check("mwdata", MemWriteData, val);
      tick();
    end
    Step = 1'b0;
    InstrValid = 1'b0;

    if (op == 2'b00) m_regs[rd] = val;
    if (op == 2'b01) m_regs[rt] = val;
    if (op == 2'b10) m_mem[ea[2:0]] = val;
    if (regw) m_last_rw = val;
    if (memw) m_last_mw = val;
    m_pc = npc;

    check("retire_pc", CurrentPC, m_pc);
    check("retire_paused", Paused, step_mode);
    check("retire_req", InstrReq, !step_mode);
    check("retire_rwv", RegWriteValid, 0);
    check("hold_rwdata", RegWriteData, m_last_rw);
    check("hold_mwdata", MemWriteData, m_last_mw);

    if (step_mode) begin
      for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
        tick();
        check("pause_hold", Paused, 1);
        check("pause_req", InstrReq, 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        Step = 1'b1;
        tick();
        Step = 1'b0;
      end else begin
        StepMode = 1'b0;
        tick();
      end
      check("resume_req", InstrReq, 1);
      check("resume_paused", Paused, 0);
      check("resume_pc", CurrentPC, m_pc);
    end
  endtask

  initial begin
    logic [7:0] rins;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b1;

    check("rst_req", InstrReq, 1);
    check("rst_pc", CurrentPC, 0);
    check("rst_rwv", RegWriteValid, 0);
    check("rst_mwv", MemWriteValid, 0);
    check("rst_rwdata", RegWriteData, 0);
    check("rst_mwdata", MemWriteData, 0);
    check("rst_paused", Paused, 0);

    run_instr(8'h1B, 0, 0, 0);
    check("add_r3", RegWriteData, 8'h03);
    check("add_pc", CurrentPC, 8'h01);
    run_instr(8'hAD, 0, 0, 0);
    check("sw_data", MemWriteData, 8'h03);
    run_instr(8'h61, 0, 0, 0);
    check("lw_data", RegWriteData, 8'h03);
    run_instr(8'h00, 0, 0, 0);
    run_instr(8'h00, 0, 0, 0);
    check("pc_before_j", CurrentPC, 8'h05);
    run_instr(8'hC2, 0, 0, 0);
    check("j_back", CurrentPC, 8'h04);
    for (int i = 0; i < 5; i++) run_instr(8'hC2, 0, 0, 0);
    check("pc_ff", CurrentPC, 8'hFF);
    run_instr(8'hC1, 0, 0, 0);
    check("j_wrap", CurrentPC, 8'h01);

    run_instr(8'h1B, 3, 0, 0);
    run_instr(8'h1B, 0, 1, 1);
    run_instr(8'hC2, 1, 1, 1);

    for (int n = 0; n < 200; n++) begin
      rins = 8'($urandom);
      run_instr(rins, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    run_instr(8'hAD, 0, 0, 0);
    StepMode = 1'b0;
    Instruction = 8'h61;
    InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    tick();
    tick();
    check("pre_rst_mem_state_rwv", RegWriteValid, 0);
    Reset = 1'b0;
    #1;
    check("midrst_pc", CurrentPC, 0);
    check("midrst_rwv", RegWriteValid, 0);
    check("midrst_rwdata", RegWriteData, 0);
    check("midrst_mwdata", MemWriteData, 0);
    @(posedge CLK);
    #1 Reset = 1'b1;
    model_reset();
    check("postrst_req", InstrReq, 1);
    check("postrst_pc", CurrentPC, 0);
    for (int i = 0; i < 4; i++) check("postrst_reg", dut.regs[i], 8'(i));
    for (int i = 0; i < 8; i++) check("postrst_mem", dut.mem[i], 0);
    tick();
    check("postrst_idle_rwv", RegWriteValid, 0);
    run_instr(8'h1B, 0, 0, 0);
    check("postrst_add", RegWriteData, 8'h03);
    for (int n = 0; n < 20; n++) run_instr(8'($urandom), 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
